// File: rtl/edge_pair_feeder_if.sv
// edge_pair_feeder_if: pair handshake bundle between the feeder and the edge comparator.
//   out_valid          feeder -> comparator, pair on the bus is valid
//   out_ready          comparator -> feeder, pair accepted this cycle
//   d1/d2              destination indices 2k and 2k+1
//   e1/e2              edge words of d1/d2 (bit EDGE_W-1 = update flag)
//   dv1/dv2            destination distances of d1/d2
`timescale 1ns/1ps
interface edge_pair_feeder_if #(
    parameter int unsigned IDX_W  = 7,
    parameter int unsigned EDGE_W = 32,
    parameter int unsigned DIST_W = 25
) ();
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  d1;
    logic [IDX_W-1:0]  d2;
    logic [EDGE_W-1:0] e1;
    logic [EDGE_W-1:0] e2;
    logic [DIST_W-1:0] dv1;
    logic [DIST_W-1:0] dv2;

    modport master (
        output out_valid, d1, d2, e1, e2, dv1, dv2,
        input  out_ready
    );

    modport slave (
        input  out_valid, d1, d2, e1, e2, dv1, dv2,
        output out_ready
    );
endinterface

// File: rtl/edge_pair_feeder.sv
// edge_pair_feeder: walks one adjacency row of the edge RAM and hands destination
// pairs (2k, 2k+1) with their edge words and distances to the edge comparator.
//   clk, reset_n       clock, asynchronous active-low reset
//   start, src         begin a row for source vertex src (sampled in IDLE only)
//   e_addr / e_rdata   edge RAM port {src, dst}, 1-cycle read latency
//   dv_addr / dv_rdata distance RAM port (dst), 1-cycle read latency
//   pair               master side of the pair handshake bundle
//   busy               high whenever the FSM is not in IDLE
//   done               one-cycle pulse at row end
//   row_upd            OR of the update flag over emitted edges of the last row
// Optional feature: define FEEDER_SKIP_EMPTY_EN to drop pairs whose two weights are zero.
`timescale 1ns/1ps
module edge_pair_feeder #(
    parameter int unsigned VERTS  = 128,
    parameter int unsigned EDGE_W = 32,
    parameter int unsigned DIST_W = 25
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [$clog2(VERTS)-1:0]     src,
    output logic [2*$clog2(VERTS)-1:0]   e_addr,
    input  logic [EDGE_W-1:0]            e_rdata,
    output logic [$clog2(VERTS)-1:0]     dv_addr,
    input  logic [DIST_W-1:0]            dv_rdata,
    output logic                         busy,
    output logic                         done,
    output logic                         row_upd,
    edge_pair_feeder_if.master           pair
);
    localparam int unsigned IDX_W = $clog2(VERTS);
    localparam int unsigned K_W   = IDX_W - 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(VERTS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        CAPTURE,
        PRESENT,
        DONE
    } state_t;

    state_t              state_q,     state_nxt;
    logic [IDX_W-1:0]    src_q,       src_nxt;
    logic [K_W-1:0]      k_q,         k_nxt;
    logic [2*IDX_W-1:0]  e_addr_q,    e_addr_nxt;
    logic [IDX_W-1:0]    dv_addr_q,   dv_addr_nxt;
    logic                busy_q,      busy_nxt;
    logic                done_q,      done_nxt;
    logic                row_upd_q,   row_upd_nxt;
    logic                out_valid_q, out_valid_nxt;
    logic [IDX_W-1:0]    d1_q,        d1_nxt;
    logic [IDX_W-1:0]    d2_q,        d2_nxt;
    logic [EDGE_W-1:0]   e1_q,        e1_nxt;
    logic [EDGE_W-1:0]   e2_q,        e2_nxt;
    logic [DIST_W-1:0]   dv1_q,       dv1_nxt;
    logic [DIST_W-1:0]   dv2_q,       dv2_nxt;

    logic [K_W-1:0]      k_inc;
    logic [IDX_W-1:0]    dst_even;
    logic [IDX_W-1:0]    dst_odd;
    logic [IDX_W-1:0]    next_even;
    logic                skip_pair;
    logic                advance;

    assign k_inc     = k_q + K_W'(1);
    assign dst_even  = {k_q, 1'b0};
    assign dst_odd   = {k_q, 1'b1};
    assign next_even = {k_inc, 1'b0};

    // Empty pair: captured e1 weight and the e2 weight arriving this cycle are both zero.
`ifdef FEEDER_SKIP_EMPTY_EN
    assign skip_pair = (e1_q[EDGE_W-2:0] == '0) && (e_rdata[EDGE_W-2:0] == '0);
`else
    assign skip_pair = 1'b0;
`endif

    // Next-state and next-output logic; addresses are set one cycle ahead of the fetch state.
    always_comb begin
        state_nxt     = state_q;
        src_nxt       = src_q;
        k_nxt         = k_q;
        e_addr_nxt    = e_addr_q;
        dv_addr_nxt   = dv_addr_q;
        row_upd_nxt   = row_upd_q;
        out_valid_nxt = out_valid_q;
        d1_nxt        = d1_q;
        d2_nxt        = d2_q;
        e1_nxt        = e1_q;
        e2_nxt        = e2_q;
        dv1_nxt       = dv1_q;
        dv2_nxt       = dv2_q;
        advance       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_nxt     = src;
                    k_nxt       = '0;
                    row_upd_nxt = 1'b0;
                    e_addr_nxt  = {src, IDX_W'(0)};
                    dv_addr_nxt = '0;
                    state_nxt   = FETCH_A;
                end
            end
            FETCH_A: begin
                e_addr_nxt  = {src_q, dst_odd};
                dv_addr_nxt = dst_odd;
                state_nxt   = FETCH_B;
            end
            FETCH_B: begin
                e1_nxt    = e_rdata;
                dv1_nxt   = dv_rdata;
                d1_nxt    = dst_even;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                e2_nxt  = e_rdata;
                dv2_nxt = dv_rdata;
                d2_nxt  = dst_odd;
                if (skip_pair) begin
                    advance = 1'b1;
                end else begin
                    out_valid_nxt = 1'b1;
                    state_nxt     = PRESENT;
                end
            end
            PRESENT: begin
                if (pair.out_ready) begin
                    out_valid_nxt = 1'b0;
                    row_upd_nxt   = row_upd_q | e1_q[EDGE_W-1] | e2_q[EDGE_W-1];
                    advance       = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Move to the next pair, or finish after the last one (k never wraps).
        if (advance) begin
            if (k_q == K_LAST) begin
                state_nxt = DONE;
            end else begin
                k_nxt       = k_inc;
                e_addr_nxt  = {src_q, next_even};
                dv_addr_nxt = next_even;
                state_nxt   = FETCH_A;
            end
        end

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            k_q         <= '0;
            e_addr_q    <= '0;
            dv_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            row_upd_q   <= 1'b0;
            out_valid_q <= 1'b0;
            d1_q        <= '0;
            d2_q        <= '0;
            e1_q        <= '0;
            e2_q        <= '0;
            dv1_q       <= '0;
            dv2_q       <= '0;
        end else begin
            state_q     <= state_nxt;
            src_q       <= src_nxt;
            k_q         <= k_nxt;
            e_addr_q    <= e_addr_nxt;
            dv_addr_q   <= dv_addr_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            row_upd_q   <= row_upd_nxt;
            out_valid_q <= out_valid_nxt;
            d1_q        <= d1_nxt;
            d2_q        <= d2_nxt;
            e1_q        <= e1_nxt;
            e2_q        <= e2_nxt;
            dv1_q       <= dv1_nxt;
            dv2_q       <= dv2_nxt;
        end
    end

    assign e_addr         = e_addr_q;
    assign dv_addr        = dv_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign row_upd        = row_upd_q;
    assign pair.out_valid = out_valid_q;
    assign pair.d1        = d1_q;
    assign pair.d2        = d2_q;
    assign pair.e1        = e1_q;
    assign pair.e2        = e2_q;
    assign pair.dv1       = dv1_q;
    assign pair.dv2       = dv2_q;
endmodule
